// File: rtl/pipeline_elastic.sv
// Elastic register pipeline: a STAGES-deep chain of WIDTH-bit words, each
// stage with its own valid bit, valid/ready backpressure, bubble collapse,
// synchronous flush and a registered occupancy count.
module pipeline_elastic #(
  parameter  int STAGES = 4,
  parameter  int WIDTH  = 32,
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_d;
  logic              in_accept;

  // Ready chain: a stage can move when it is empty or everything after it
  // can move, so a full pipe still streams when the sink is ready.
  always_comb begin : ready_chain
    logic chain;
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    chain = out_ready;
    rdy   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = ~v_q[i] | chain;
      rdy[i] = chain;
    end
  end

  assign in_ready  = rdy[0] & ~flush & rst;
  assign in_accept = in_valid & in_ready;

  // Next-state valid bits and data load enables; flush overrides everything.
  always_comb begin
    v_d = v_q;
    ld  = '0;
    if (rdy[0]) begin
      v_d[0] = in_accept;
      ld[0]  = in_accept;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        ld[i]  = v_q[i-1];
      end
    end
    if (flush) begin
      v_d = '0;
      ld  = '0;
    end
  end

  // Data source for each stage: the upstream word or the previous stage.
  always_comb begin
    d_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      d_d[i] = d_q[i-1];
    end
  end

  // Popcount of the next valid vector so occupancy tracks v on the same edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + CNT_W'(v_d[i]);
    end
  end

  // Valid bits and occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // Data registers: load only on a valid transfer, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data array is reset too, so out_data reads 0 after reset
    // instead of stale contents; this costs a reset net on every data flop.
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          d_q[i] <= d_d[i];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1] & ~flush;
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_elastic.sv
// Self-checking bench for pipeline_elastic: a 3-stage and a 1-stage instance
// share clock and reset; a per-instance scoreboard queue holds accepted words
// in order and is popped whenever the instance completes an output transfer.
module tb_pipeline_elastic;

  logic       clk;
  logic       rst;

  logic       flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [7:0] in_data3, out_data3;
  logic [1:0] occ3;

  logic       flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] in_data1, out_data1;
  logic [0:0] occ1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ent_t;

  ent_t q3[$];
  ent_t q1[$];

  int tests, fails;
  int cyc_n;
  int first_acc, first_out, last_out, n_acc, n_out, occ_max;
  int n_out1;
  bit acc1_prev;

  pipeline_elastic #(.STAGES(3), .WIDTH(8)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush3),
    .in_valid (in_valid3),
    .in_data  (in_data3),
    .in_ready (in_ready3),
    .out_valid(out_valid3),
    .out_data (out_data3),
    .out_ready(out_ready3),
    .occupancy(occ3)
  );

  pipeline_elastic #(.STAGES(1), .WIDTH(8)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush1),
    .in_valid (in_valid1),
    .in_data  (in_data1),
    .in_ready (in_ready1),
    .out_valid(out_valid1),
    .out_data (out_data1),
    .out_ready(out_ready1),
    .occupancy(occ1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic clr_stats();
    first_acc = -1;
    first_out = -1;
    last_out  = -1;
    n_acc     = 0;
    n_out     = 0;
    occ_max   = 0;
  endtask

  // One clock cycle: settle, account handshakes on both instances, then
  // advance to the next falling edge where new stimulus is driven.
  task automatic cyc();
    ent_t e;
    #1;
    if (in_valid3 && in_ready3) begin
      e.data = in_data3;
      e.cyc  = cyc_n;
      q3.push_back(e);
      n_acc++;
      if (first_acc < 0) first_acc = cyc_n;
    end
    if (out_valid3 && out_ready3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL sb3_unexpected: got %h, expected no output", out_data3);
      end else begin
        e = q3.pop_front();
        if (out_data3 !== e.data) begin
          fails++;
          $display("FAIL sb3_data: got %h, expected %h", out_data3, e.data);
        end
      end
      n_out++;
      if (first_out < 0) first_out = cyc_n;
      last_out = cyc_n;
    end
    if (flush3) q3.delete();
    if (int'(occ3) > occ_max) occ_max = int'(occ3);

    if (acc1_prev) begin
      tests++;
      if (out_valid1 !== 1'b1) begin
        fails++;
        $display("FAIL s1_latency: out_valid=%b, expected 1 one cycle after accept", out_valid1);
      end
    end
    acc1_prev = in_valid1 && in_ready1;
    if (acc1_prev) begin
      e.data = in_data1;
      e.cyc  = cyc_n;
      q1.push_back(e);
    end
    if (out_valid1 && out_ready1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected: got %h, expected no output", out_data1);
      end else begin
        e = q1.pop_front();
        if (out_data1 !== e.data) begin
          fails++;
          $display("FAIL sb1_data: got %h, expected %h", out_data1, e.data);
        end
      end
      n_out1++;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid3); end
    tests++; if (out_data3 !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h, expected 00", out_data3); end
    tests++; if (in_ready3 !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready3); end
    tests++; if (occ3 !== 2'd0) begin fails++; $display("FAIL rst_occ: got %0d, expected 0", occ3); end
    tests++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin
      fails++; $display("FAIL rst_s1: in_ready=%b out_valid=%b, expected 0 0", in_ready1, out_valid1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready3); end
    tests++; if (occ3 !== 2'd0) begin fails++; $display("FAIL post_rst_occ: got %0d, expected 0", occ3); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    clr_stats();
    out_ready3 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid3 = 1'b1;
      in_data3  = 8'(k);
      #1;
      tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL stream_in_ready: got %b, expected 1", in_ready3); end
      cyc();
    end
    in_valid3 = 1'b0;
    in_data3  = 8'h00;
    for (int i = 0; i < 8; i++) cyc();
    tests++; if (n_out != 5) begin fails++; $display("FAIL stream_count: got %0d, expected 5", n_out); end
    tests++; if (first_out - first_acc != 3) begin fails++; $display("FAIL stream_latency: got %0d, expected 3", first_out - first_acc); end
    tests++; if (last_out - first_out != 4) begin fails++; $display("FAIL stream_b2b: span %0d, expected 4", last_out - first_out); end
    tests++; if (occ_max != 3) begin fails++; $display("FAIL stream_occ_peak: got %0d, expected 3", occ_max); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    clr_stats();
    out_ready3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid3 = 1'b1;
      in_data3  = words[k];
      #1;
      tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL bp_fill_ready: got %b, expected 1", in_ready3); end
      cyc();
    end
    in_data3 = 8'hA4;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (in_ready3 !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b, expected 0", in_ready3); end
      tests++; if (occ3 !== 2'd3) begin fails++; $display("FAIL bp_occ: got %0d, expected 3", occ3); end
      tests++; if (out_valid3 !== 1'b1 || out_data3 !== 8'hA1) begin
        fails++; $display("FAIL bp_hold: valid=%b data=%h, expected 1 a1", out_valid3, out_data3);
      end
      cyc();
    end
    out_ready3 = 1'b1;
    #1;
    tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b, expected 1", in_ready3); end
    cyc();
    in_valid3 = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    tests++; if (n_acc != 4 || n_out != 4) begin
      fails++; $display("FAIL bp_counts: acc=%0d out=%0d, expected 4 4", n_acc, n_out);
    end
  endtask

  task automatic test_bubble();
    clr_stats();
    out_ready3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid3 = (i % 2 == 0) && (i < 5);
      in_data3  = in_valid3 ? 8'((i / 2 + 1) * 16) : 8'h00;
      if (in_valid3) begin
        #1;
        tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL bubble_accept: got %b, expected 1", in_ready3); end
      end
      cyc();
    end
    in_valid3 = 1'b0;
    #1;
    tests++; if (occ3 !== 2'd3) begin fails++; $display("FAIL bubble_occ: got %0d, expected 3", occ3); end
    tests++; if (in_ready3 !== 1'b0) begin fails++; $display("FAIL bubble_packed_ready: got %b, expected 0", in_ready3); end
    tests++; if (out_data3 !== 8'h10) begin fails++; $display("FAIL bubble_head: got %h, expected 10", out_data3); end
    out_ready3 = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    tests++; if (n_out != 3 || last_out - first_out != 2) begin
      fails++; $display("FAIL bubble_drain: out=%0d span=%0d, expected 3 2", n_out, last_out - first_out);
    end
  endtask

  task automatic test_flush();
    clr_stats();
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_data3 = 8'hB1; cyc();
    in_valid3 = 1'b1; in_data3 = 8'hB2; cyc();
    in_data3 = 8'hB3;
    flush3   = 1'b1;
    #1;
    tests++; if (in_ready3 !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b, expected 0", in_ready3); end
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b, expected 0", out_valid3); end
    cyc();
    flush3 = 1'b0;
    #1;
    tests++; if (occ3 !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d, expected 0", occ3); end
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL flush_cleared: got %b, expected 0", out_valid3); end
    clr_stats();
    cyc();
    in_valid3 = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    tests++; if (n_out != 1 || first_out - first_acc != 3) begin
      fails++; $display("FAIL flush_reaccept: out=%0d latency=%0d, expected 1 3", n_out, first_out - first_acc);
    end
    flush3 = 1'b1; in_valid3 = 1'b1; in_data3 = 8'hEE;
    cyc();
    cyc();
    flush3 = 1'b0; in_valid3 = 1'b0;
    #1;
    tests++; if (occ3 !== 2'd0 || out_valid3 !== 1'b0) begin
      fails++; $display("FAIL flush_hold: occ=%0d valid=%b, expected 0 0", occ3, out_valid3);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    clr_stats();
    out_ready3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid3 = 1'b1;
      in_data3  = 8'hC1 + 8'(k);
      cyc();
    end
    in_valid3 = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL arst_out_valid: got %b, expected 0", out_valid3); end
    tests++; if (occ3 !== 2'd0) begin fails++; $display("FAIL arst_occ: got %0d, expected 0", occ3); end
    tests++; if (in_ready3 !== 1'b0 || out_data3 !== 8'h00) begin
      fails++; $display("FAIL arst_misc: in_ready=%b data=%h, expected 0 00", in_ready3, out_data3);
    end
    q3.delete();
    @(negedge clk);
    rst = 1'b1;
    clr_stats();
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    in_data3   = 8'h55;
    cyc();
    in_valid3 = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    tests++; if (n_out != 1 || first_out - first_acc != 3) begin
      fails++; $display("FAIL arst_restart: out=%0d latency=%0d, expected 1 3", n_out, first_out - first_acc);
    end
  endtask

  task automatic test_single_stage();
    int k;
    int n;
    k = 0;
    n = 0;
    n_out1 = 0;
    in_valid1 = 1'b1;
    while (k < 256 && n < 3000) begin
      out_ready1 = ($urandom_range(0, 3) != 0);
      in_data1   = k[7:0];
      cyc();
      if (acc1_prev) k++;
      n++;
    end
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    tests++; if (k != 256) begin fails++; $display("FAIL s1_accepted: got %0d, expected 256", k); end
    tests++; if (n_out1 != 256 || q1.size() != 0) begin
      fails++; $display("FAIL s1_drain: out=%0d left=%0d, expected 256 0", n_out1, q1.size());
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cyc_n      = 0;
    n_out1     = 0;
    acc1_prev  = 1'b0;
    rst        = 1'b0;
    flush3     = 1'b0;
    in_valid3  = 1'b0;
    in_data3   = 8'h00;
    out_ready3 = 1'b0;
    flush1     = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = 8'h00;
    out_ready1 = 1'b0;
    clr_stats();

    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_single_stage();

    tests++;
    if (q3.size() != 0) begin
      fails++;
      $display("FAIL sb3_leftover: %0d words, expected 0", q3.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
